// File: rtl/elastic_pe_param.sv
// Elastic processing element: sequences a small context program over neighbour handshake ports.
// Optional RUN-stall counter output (stall_cycles) is built only when ELASTIC_PE_PERF_EN is defined.
module elastic_pe_param #(
  parameter int DATA_WIDTH    = 32,
  parameter int NEIGHBOR_NUM  = 4,
  parameter int CONTEXT_DEPTH = 8,
  parameter int REG_DEPTH     = 2,
  parameter int BUF_DEPTH     = 2,
  localparam int CW = $clog2(CONTEXT_DEPTH)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               cfg_we,
  input  logic [CW-1:0]                      cfg_index,
  input  logic [7:0]                         cfg_src_a,
  input  logic [7:0]                         cfg_src_b,
  input  logic [NEIGHBOR_NUM-1:0]            cfg_dst_mask,
  input  logic [3:0]                         cfg_op,
  input  logic [DATA_WIDTH-1:0]              cfg_const,
  input  logic                               start,
  input  logic [CW-1:0]                      ctx_max,
  input  logic [15:0]                        iter_count,
  input  logic [NEIGHBOR_NUM*DATA_WIDTH-1:0] in_data,
  input  logic [NEIGHBOR_NUM-1:0]            in_valid,
  output logic [NEIGHBOR_NUM-1:0]            in_stop,
  output logic [NEIGHBOR_NUM*DATA_WIDTH-1:0] out_data,
  output logic [NEIGHBOR_NUM-1:0]            out_valid,
  input  logic [NEIGHBOR_NUM-1:0]            out_stop,
  output logic                               busy,
  output logic                               done
`ifdef ELASTIC_PE_PERF_EN
  ,
  output logic [31:0]                        stall_cycles
`endif
);

  // state | meaning
  // IDLE  | waiting for start, config writable
  // RUN   | issuing one context per fire
  // DRAIN | program finished, emptying output FIFO
  // DONE  | one-cycle done pulse, config writable
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam int RW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam int BW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int NW = $clog2(BUF_DEPTH + 1);
  localparam logic [3:0] OP_CONST = 4'd7;

  state_t state, state_nxt;

  logic [7:0]              mem_src_a [CONTEXT_DEPTH];
  logic [7:0]              mem_src_b [CONTEXT_DEPTH];
  logic [NEIGHBOR_NUM-1:0] mem_mask  [CONTEXT_DEPTH];
  logic [3:0]              mem_op    [CONTEXT_DEPTH];
  logic [DATA_WIDTH-1:0]   mem_const [CONTEXT_DEPTH];

  logic [DATA_WIDTH-1:0]   regs [REG_DEPTH];
  logic [DATA_WIDTH-1:0]   fifo_data [BUF_DEPTH];
  logic [NEIGHBOR_NUM-1:0] fifo_mask [BUF_DEPTH];

  logic [CW-1:0]           ctx, ctx_last;
  logic [RW-1:0]           reg_ptr;
  logic [15:0]             remaining;
  logic [BW-1:0]           rd_ptr, wr_ptr;
  logic [NW-1:0]           fifo_count;
  logic [NEIGHBOR_NUM-1:0] sent;

  logic [7:0]              cur_src_a, cur_src_b;
  logic [3:0]              cur_op;
  logic [DATA_WIDTH-1:0]   cur_const, a_val, b_val, result;
  logic [NEIGHBOR_NUM-1:0] need, head_mask, out_accept;
  logic                    start_ok, cfg_open, fire, ctx_wrap;
  logic                    fifo_full, fifo_empty, pop;

  assign cfg_open  = (state == S_IDLE) || (state == S_DONE);
  assign start_ok  = start && cfg_open;
  assign cur_src_a = mem_src_a[ctx];
  assign cur_src_b = mem_src_b[ctx];
  assign cur_op    = mem_op[ctx];
  assign cur_const = mem_const[ctx];
  assign ctx_wrap  = (ctx == ctx_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CONTEXT_DEPTH; i++) begin
        mem_src_a[i] <= '0;
        mem_src_b[i] <= '0;
        mem_mask[i]  <= '0;
        mem_op[i]    <= '0;
        mem_const[i] <= '0;
      end
    end else if (cfg_we && cfg_open) begin
      mem_src_a[cfg_index] <= cfg_src_a;
      mem_src_b[cfg_index] <= cfg_src_b;
      mem_mask[cfg_index]  <= cfg_dst_mask;
      mem_op[cfg_index]    <= cfg_op;
      mem_const[cfg_index] <= cfg_const;
    end
  end

  // Operand decode: a port selected by both operands is consumed only once.
  always_comb begin
    a_val = '0;
    b_val = '0;
    need  = '0;
    for (int p = 0; p < NEIGHBOR_NUM; p++) begin
      if (32'(cur_src_a) == p) begin
        a_val   = in_data[p*DATA_WIDTH +: DATA_WIDTH];
        need[p] = 1'b1;
      end
      if (32'(cur_src_b) == p) begin
        b_val   = in_data[p*DATA_WIDTH +: DATA_WIDTH];
        need[p] = 1'b1;
      end
    end
    for (int r = 0; r < REG_DEPTH; r++) begin
      if (32'(cur_src_a) == NEIGHBOR_NUM + r) a_val = regs[r];
      if (32'(cur_src_b) == NEIGHBOR_NUM + r) b_val = regs[r];
    end
    if (cur_op == OP_CONST) need = '0;
  end

  assign fire    = (state == S_RUN) && ((in_valid & need) == need) && !fifo_full;
  assign in_stop = fire ? ~need : '1;

  always_comb begin
    result = '0;
    case (cur_op)
      4'd0:    result = a_val;
      4'd1:    result = a_val + b_val;
      4'd2:    result = a_val - b_val;
      4'd3:    result = a_val * b_val;
      4'd4:    result = a_val & b_val;
      4'd5:    result = a_val | b_val;
      4'd6:    result = a_val ^ b_val;
      4'd7:    result = cur_const;
      4'd8:    result = a_val + cur_const;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctx       <= '0;
      ctx_last  <= '0;
      reg_ptr   <= '0;
      remaining <= '0;
      for (int r = 0; r < REG_DEPTH; r++) regs[r] <= '0;
    end else if (start_ok) begin
      ctx       <= '0;
      ctx_last  <= ctx_max;
      reg_ptr   <= '0;
      remaining <= iter_count;
    end else if (fire) begin
      regs[reg_ptr] <= result;
      ctx     <= ctx_wrap ? '0 : ctx + CW'(1);
      reg_ptr <= (reg_ptr == RW'(REG_DEPTH - 1)) ? '0 : reg_ptr + RW'(1);
      if (ctx_wrap && remaining != 16'd0) remaining <= remaining - 16'd1;
    end
  end

  assign fifo_full  = (fifo_count == NW'(BUF_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign head_mask  = fifo_mask[rd_ptr];
  assign out_valid  = fifo_empty ? '0 : (head_mask & ~sent);
  assign out_accept = out_valid & ~out_stop;
  assign pop        = !fifo_empty && ((head_mask & ~(sent | out_accept)) == '0);
  assign out_data   = {NEIGHBOR_NUM{fifo_data[rd_ptr]}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      sent       <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_mask[i] <= '0;
      end
    end else begin
      if (fire) begin
        fifo_data[wr_ptr] <= result;
        fifo_mask[wr_ptr] <= mem_mask[ctx];
        wr_ptr <= (wr_ptr == BW'(BUF_DEPTH - 1)) ? '0 : wr_ptr + BW'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == BW'(BUF_DEPTH - 1)) ? '0 : rd_ptr + BW'(1);
      case ({fire, pop})
        2'b10:   fifo_count <= fifo_count + NW'(1);
        2'b01:   fifo_count <= fifo_count - NW'(1);
        default: fifo_count <= fifo_count;
      endcase
      sent <= pop ? '0 : (sent | out_accept);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (fire && ctx_wrap && remaining == 16'd1) state_nxt = S_DRAIN;
      S_DRAIN: if (fifo_empty) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN) || (state == S_DRAIN);
    done = (state == S_DONE);
  end

`ifdef ELASTIC_PE_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                             stall_cycles <= '0;
    else if (start_ok)                                        stall_cycles <= '0;
    else if (state == S_RUN && !fire && stall_cycles != '1)   stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_elastic_pe_param.sv
// Randomized bench for elastic_pe_param against a fire-sequence model of the context program.
module tb_elastic_pe_param;
  localparam int DW = 32, NN = 4, CD = 8, RD = 2, BD = 2, CW = 3;

  logic clk = 1'b0, reset_n = 1'b0;
  logic cfg_we = 1'b0;
  logic [CW-1:0] cfg_index = '0;
  logic [7:0] cfg_src_a = '0, cfg_src_b = '0;
  logic [NN-1:0] cfg_dst_mask = '0;
  logic [3:0] cfg_op = '0;
  logic [DW-1:0] cfg_const = '0;
  logic start = 1'b0;
  logic [CW-1:0] ctx_max = '0;
  logic [15:0] iter_count = '0;
  logic [NN*DW-1:0] in_data = '0;
  logic [NN-1:0] in_valid = '0, in_stop;
  logic [NN*DW-1:0] out_data;
  logic [NN-1:0] out_valid, out_stop = '0;
  logic busy, done;
`ifdef ELASTIC_PE_PERF_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  elastic_pe_param #(.DATA_WIDTH(DW), .NEIGHBOR_NUM(NN), .CONTEXT_DEPTH(CD),
                     .REG_DEPTH(RD), .BUF_DEPTH(BD)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_index(cfg_index),
    .cfg_src_a(cfg_src_a), .cfg_src_b(cfg_src_b), .cfg_dst_mask(cfg_dst_mask),
    .cfg_op(cfg_op), .cfg_const(cfg_const), .start(start), .ctx_max(ctx_max),
    .iter_count(iter_count), .in_data(in_data), .in_valid(in_valid), .in_stop(in_stop),
    .out_data(out_data), .out_valid(out_valid), .out_stop(out_stop), .busy(busy), .done(done)
`ifdef ELASTIC_PE_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  int vectors = 0, miscompares = 0;
  logic [7:0] sh_sa [CD], sh_sb [CD];
  logic [NN-1:0] sh_mask [CD];
  logic [3:0] sh_op [CD];
  logic [DW-1:0] sh_k [CD];
  logic [DW-1:0] m_regs [RD];
  logic [DW-1:0] in_q [NN][$];
  logic [DW-1:0] exp_q [NN][$];
  logic [DW-1:0] pre_q [NN][$];
  int valid_pct = 100, stop_pct = 0;
  int hold_off [NN], stop_hold [NN];
  bit clr_v [NN];
  bit start_pend = 0;
  int rel = 0, run_wr_at = -100;
  int win_left = 0, win_x0 = 0, win_a2 = 0, win_stop0_low = 0;
  int done_seen = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] alu(logic [3:0] op, logic [DW-1:0] a, logic [DW-1:0] b,
                                        logic [DW-1:0] k);
    case (op)
      4'd0: return a;
      4'd1: return a + b;
      4'd2: return a - b;
      4'd3: return a * b;
      4'd4: return a & b;
      4'd5: return a | b;
      4'd6: return a ^ b;
      4'd7: return k;
      4'd8: return a + k;
      default: return '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] operand(logic [7:0] s, logic [DW-1:0] pv [NN]);
    int si = int'(s);
    if (si < NN) return pv[si];
    if (si < NN + RD) return m_regs[si - NN];
    return '0;
  endfunction

  // Expected results per fire, in program order; port values are drawn in consumption order.
  task automatic build_model(int cmax, int iters);
    int ptr = 0;
    for (int it = 0; it < iters; it++) begin
      for (int c = 0; c <= cmax; c++) begin
        logic [DW-1:0] pv [NN];
        logic [DW-1:0] r;
        for (int p = 0; p < NN; p++) begin
          pv[p] = '0;
          if (sh_op[c] != 4'd7 && (int'(sh_sa[c]) == p || int'(sh_sb[c]) == p)) begin
            pv[p] = (pre_q[p].size() > 0) ? pre_q[p].pop_front() : DW'($urandom);
            in_q[p].push_back(pv[p]);
          end
        end
        r = alu(sh_op[c], operand(sh_sa[c], pv), operand(sh_sb[c], pv), sh_k[c]);
        for (int p = 0; p < NN; p++) if (sh_mask[c][p]) exp_q[p].push_back(r);
        m_regs[ptr] = r;
        ptr = (ptr + 1) % RD;
      end
    end
  endtask

  task automatic write_cfg(int idx, int sa, int sb, int mask, int op, logic [DW-1:0] k);
    @(negedge clk);
    cfg_we = 1'b1; cfg_index = CW'(idx); cfg_src_a = 8'(sa); cfg_src_b = 8'(sb);
    cfg_dst_mask = NN'(mask); cfg_op = 4'(op); cfg_const = k;
    sh_sa[idx] = 8'(sa); sh_sb[idx] = 8'(sb); sh_mask[idx] = NN'(mask);
    sh_op[idx] = 4'(op); sh_k[idx] = k;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic cycle();
    @(negedge clk);
    start = start_pend;
    start_pend = 1'b0;
    if (rel == run_wr_at) begin
      cfg_we = 1'b1; cfg_index = '0; cfg_op = 4'd6; cfg_src_a = 8'd0; cfg_src_b = 8'd1;
      cfg_dst_mask = 4'b0001;
    end else cfg_we = 1'b0;
    for (int p = 0; p < NN; p++) begin
      if (clr_v[p]) begin in_valid[p] = 1'b0; clr_v[p] = 1'b0; end
      if (!in_valid[p] && hold_off[p] == 0 && in_q[p].size() > 0 &&
          int'($urandom_range(99)) < valid_pct) begin
        in_valid[p] = 1'b1;
        in_data[p*DW +: DW] = in_q[p][0];
      end
      if (hold_off[p] > 0) hold_off[p]--;
      if (stop_hold[p] > 0) begin out_stop[p] = 1'b1; stop_hold[p]--; end
      else out_stop[p] = (int'($urandom_range(99)) < stop_pct);
    end
    #4;
    for (int p = 0; p < NN; p++) begin
      if (!in_valid[p]) check($sformatf("in_stop_idle_p%0d", p), 64'(in_stop[p]), 64'd1);
      if (in_valid[p] && !in_stop[p]) begin
        if (in_q[p].size() > 0) void'(in_q[p].pop_front());
        clr_v[p] = 1'b1;
        if (p == 0 && win_left > 0) win_x0++;
      end
      if (out_valid[p] && !out_stop[p]) begin
        if (exp_q[p].size() == 0) check($sformatf("out_extra_p%0d", p), 64'(out_valid[p]), 64'd0);
        else check($sformatf("out_data_p%0d", p), 64'(out_data[p*DW +: DW]), 64'(exp_q[p].pop_front()));
        if (p == 2 && win_left > 0) win_a2++;
      end
    end
    if (win_left > 0) begin
      if (!in_stop[0]) win_stop0_low++;
      win_left--;
    end
    if (done) begin
      done_seen++;
      check("busy_at_done", 64'(busy), 64'd0);
    end
    rel++;
  endtask

  task automatic run_job(int cmax, int iters, string tag);
    ctx_max = CW'(cmax);
    iter_count = 16'(iters);
    done_seen = 0;
    rel = 0;
    start_pend = 1'b1;
    for (int n = 0; n < 3000 && done_seen == 0; n++) cycle();
    check({tag, "_done_pulse"}, 64'(done_seen), 64'd1);
    cycle();
    check({tag, "_done_low"}, 64'(done), 64'd0);
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
    check({tag, "_out_valid_idle"}, 64'(out_valid), 64'd0);
    for (int p = 0; p < NN; p++) begin
      check($sformatf("%s_exp_left_p%0d", tag, p), 64'(exp_q[p].size()), 64'd0);
      check($sformatf("%s_in_left_p%0d", tag, p), 64'(in_q[p].size()), 64'd0);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < CD; i++) begin
      sh_sa[i] = '0; sh_sb[i] = '0; sh_mask[i] = '0; sh_op[i] = '0; sh_k[i] = '0;
    end
    for (int r = 0; r < RD; r++) m_regs[r] = '0;
    for (int p = 0; p < NN; p++) begin
      in_q[p].delete(); exp_q[p].delete(); pre_q[p].delete();
      hold_off[p] = 0; stop_hold[p] = 0; clr_v[p] = 1'b0;
    end
    in_valid = '0;
  endtask

  initial begin
    int cnt;
    clear_model();
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_stop", 64'(in_stop), 64'hF);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    reset_n = 1'b1;

    // Basic add stream
    write_cfg(0, 0, 1, 4'b0001, 1, '0);
    pre_q[0] = '{32'd5, 32'd6, 32'd7};
    pre_q[1] = '{32'd1, 32'd1, 32'd1};
    build_model(0, 3);
    check("pin_add_n", 64'(exp_q[0].size()), 64'd3);
    check("pin_add_0", 64'(exp_q[0][0]), 64'd6);
    check("pin_add_1", 64'(exp_q[0][1]), 64'd7);
    check("pin_add_2", 64'(exp_q[0][2]), 64'd8);
    run_job(0, 3, "add");

    // Port1 late: nothing may be consumed from port0 meanwhile
    hold_off[1] = 5;
    win_left = 5; win_x0 = 0; win_stop0_low = 0;
    build_model(0, 3);
    run_job(0, 3, "late");
    check("late_port0_xfers", 64'(win_x0), 64'd0);
    check("late_in_stop0_low", 64'(win_stop0_low), 64'd0);
`ifdef ELASTIC_PE_PERF_EN
    check("late_stall_cycles", 64'(stall_cycles), 64'd4);
`endif

    // Multicast with a stalled destination fills the FIFO
    write_cfg(0, 0, 255, 4'b0110, 0, '0);
    pre_q[0] = '{32'd10, 32'd20, 32'd30};
    stop_hold[1] = 5;
    win_left = 5; win_x0 = 0; win_a2 = 0;
    build_model(0, 3);
    check("pin_mc_2", 64'(exp_q[1][2]), 64'd30);
    run_job(0, 3, "mcast");
    check("mcast_fires_while_held", 64'(win_x0), 64'd2);
    check("mcast_port2_accepts", 64'(win_a2), 64'd1);

    // Constant plus register feedback
    write_cfg(0, 255, 255, 4'b0001, 7, 32'd9);
    write_cfg(1, NN, NN, 4'b0001, 1, '0);
    build_model(1, 2);
    check("pin_fb_0", 64'(exp_q[0][0]), 64'd9);
    check("pin_fb_1", 64'(exp_q[0][1]), 64'd18);
    check("pin_fb_2", 64'(exp_q[0][2]), 64'd9);
    check("pin_fb_3", 64'(exp_q[0][3]), 64'd18);
    run_job(1, 2, "feedback");

    // Config write while running must be ignored
    write_cfg(0, 0, 1, 4'b0001, 1, '0);
    run_wr_at = 1;
    build_model(0, 2);
    run_job(0, 2, "runwrite");
    run_wr_at = -100;

    write_cfg(0, 0, 1, 4'b0001, 12, '0);
    build_model(0, 1);
    check("pin_op12", 64'(exp_q[0][0]), 64'd0);
    run_job(0, 1, "op12");

    write_cfg(0, 0, 1, 4'b0001, 1, '0);
    pre_q[0] = '{32'hFFFF_FFFF};
    pre_q[1] = '{32'd1};
    build_model(0, 1);
    check("pin_wrap", 64'(exp_q[0][0]), 64'd0);
    run_job(0, 1, "wrap");

    // Random programs
    for (int j = 0; j < 10; j++) begin
      int cmax = int'($urandom_range(3));
      for (int c = 0; c <= cmax; c++) begin
        int sa = int'($urandom_range(NN + RD + 1));
        int sb = int'($urandom_range(NN + RD + 1));
        if (sa == NN + RD + 1) sa = 200;
        if (sb == NN + RD + 1) sb = 200;
        write_cfg(c, sa, sb, int'($urandom_range(15)), int'($urandom_range(15)), DW'($urandom));
      end
      valid_pct = int'($urandom_range(40, 100));
      stop_pct = int'($urandom_range(50));
      begin
        int iters = int'($urandom_range(1, 3));
        build_model(cmax, iters);
        run_job(cmax, iters, $sformatf("rand%0d", j));
      end
    end

    // Unbounded run, FIFO filled, then reset mid-run
    valid_pct = 100;
    stop_pct = 100;
    write_cfg(0, 0, 255, 4'b0011, 0, '0);
    build_model(0, 10);
    ctx_max = '0;
    iter_count = 16'd0;
    done_seen = 0;
    rel = 0;
    start_pend = 1'b1;
    repeat (20) cycle();
    check("unb_busy", 64'(busy), 64'd1);
    check("unb_no_done", 64'(done_seen), 64'd0);
    check("unb_out_valid", 64'(out_valid), 64'b0011);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_stop", 64'(in_stop), 64'hF);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    clear_model();
    stop_pct = 0;
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    for (int n = 0; n < 10; n++) begin
      cycle();
      if (out_valid != '0) cnt++;
    end
    check("post_rst_no_emit", 64'(cnt), 64'd0);
    check("post_rst_idle", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/elastic_pe_param.md
ELASTIC_PE_PARAM -- requirements
Module: elastic_pe_param

Interface
REQ-001 Parameter DATA_WIDTH, default 32, datapath width.
REQ-002 Parameter NEIGHBOR_NUM, default 4, neighbour input/output port count.
REQ-003 Parameter CONTEXT_DEPTH, default 8, config memory entries (power of two, CW=log2).
REQ-004 Parameter REG_DEPTH, default 2, circular result register file entries.
REQ-005 Parameter BUF_DEPTH, default 2, output FIFO entries.
REQ-006 Port clk  input  1  clock, rising edge; reset_n  input  1  asynchronous, active-low reset.
REQ-007 Ports cfg_we input 1, cfg_index input CW, cfg_src_a/cfg_src_b input 8 (operand select), cfg_dst_mask input NEIGHBOR_NUM, cfg_op input 4, cfg_const input DATA_WIDTH: config write port.
REQ-008 Ports start input 1, ctx_max input CW (last context), iter_count input 16 (loop iterations, 0 = unbounded).
REQ-009 Ports in_data input NEIGHBOR_NUM*DATA_WIDTH, in_valid input NEIGHBOR_NUM, in_stop output NEIGHBOR_NUM: upstream handshake; transfer when valid && !stop.
REQ-010 Ports out_data output NEIGHBOR_NUM*DATA_WIDTH, out_valid output NEIGHBOR_NUM, out_stop input NEIGHBOR_NUM: downstream handshake.
REQ-011 Ports busy output 1 (state RUN or DRAIN), done output 1 (one-cycle pulse).

Function
REQ-012 States IDLE, RUN, DRAIN, DONE; IDLE->RUN on start (ctx=0, iterations remaining=iter_count, reg pointer=0); start outside IDLE/DONE ignored.
REQ-013 cfg_we writes entry cfg_index only in IDLE or DONE; ignored otherwise.
REQ-014 Operand select s < NEIGHBOR_NUM reads in port s; NEIGHBOR_NUM <= s < NEIGHBOR_NUM+REG_DEPTH reads register s-NEIGHBOR_NUM (always valid); larger values read 0, always valid.
REQ-015 Fire condition: state RUN, every selected port operand valid, FIFO not full; op CONST needs no operands.
REQ-016 On fire: in_stop[p]=0 for each selected port p (same port for both operands consumed once); all other in_stop bits=1 in every cycle.
REQ-017 Ops: 0 pass a, 1 a+b, 2 a-b, 3 a*b low DATA_WIDTH bits, 4 and, 5 or, 6 xor, 7 const, 8 a+const; 9-15 yield 0; arithmetic wraps modulo 2^DATA_WIDTH.
REQ-018 On fire: result pushed into FIFO with current dst_mask, written to register[reg pointer], reg pointer increments wrapping at REG_DEPTH-1, ctx increments wrapping from ctx_max to 0; one fire per cycle max, one-cycle latency fire->FIFO head visible when FIFO empty.
REQ-019 Wrap from ctx_max on final iteration (remaining==1) moves RUN->DRAIN; iter_count=0 never leaves RUN except by reset.
REQ-020 FIFO head presented on every port whose mask bit is set and not yet accepted; out_valid[k]=1 only for those; per-port sent bits set on out_valid&&!out_stop.
REQ-021 Head pops in the cycle its last pending port accepts; mask 0 pops in one cycle with no out_valid; push and pop in the same cycle on a full FIFO allowed only if pop occurs (fire requires not-full at cycle start).
REQ-022 DRAIN->DONE when FIFO empty; DONE asserts done for one cycle then ->IDLE unless start present, which goes directly to RUN.

Reset
REQ-023 reset_n low: state IDLE, ctx, pointers, sent bits, FIFO count, registers and config memory 0; out_valid=0, in_stop all 1, busy=0, done=0.
REQ-024 Reset mid-RUN/DRAIN discards FIFO contents without emitting them; outputs take reset values asynchronously.

Configuration
REQ-025 Macro ELASTIC_PE_PERF_EN defined: output stall_cycles 32 bits counts RUN cycles without fire, saturates at all-ones, clears on start and reset; undefined: port and counter absent, behaviour otherwise identical.

Verification
REQ-026 ctx0 ADD src 0,1 mask 0001, ctx_max 0, iter 3; port0 5,6,7, port1 1,1,1 -> out port0 6,7,8, then done pulse, busy low.
REQ-027 Port1 valid delayed 4 cycles vs port0 -> no fire, in_stop[0]=1 until port1 valid, result unchanged; with PERF_EN stall_cycles=4.
REQ-028 Mask 0110, out_stop[1]=1 for 3 cycles, BUF_DEPTH 2 -> port2 accepts once, head held, FIFO fills, third fire blocked until port1 accepts.
REQ-029 ctx0 CONST 9, ctx1 ADD src NEIGHBOR_NUM (reg0) with reg0 self, ctx_max 1, iter 2 -> outputs 9, 18, 9, then reg feedback per pointer wrap matches model.
REQ-030 reset_n low during RUN with 2 FIFO entries -> out_valid 0 immediately, state IDLE, no entries emitted after release.
REQ-031 cfg_we during RUN to active ctx -> memory unchanged; op 12 -> result 0; 0xFFFFFFFF+1 -> 0.
